dt_est_ctrl: RTL
================

Name: dt_est_ctrl

Overview:
Sequencing and configuration controller for the dT estimator datapath (EMA of temperature delta, Q7.0 in/out). It accepts temperature samples and parameter updates over valid/ready handshakes, drives the estimator's T_cur/init/alpha/k_dt/d_max inputs, and issues INIT on start-up, on config change, on explicit restart and on implausible temperature jumps. It also gates published dT during a warm-up window and flags sustained saturation. It sits between the sensor front-end and the estimator instance.

Parameters:
WARMUP_SAMPLES, 8, accepted samples after INIT before dT_valid may assert (1..255)
JUMP_THR, 32, |T_new - T_last| strictly above this forces auto re-INIT (Q7.0, 1..255)
SAT_RUN, 4, consecutive saturated outputs that raise sat_alarm (1..15)
ALPHA_RST, 32, alpha loaded at reset
K_RST, 3, k_dt loaded at reset
DMAX_RST, 64, d_max loaded at reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
s_valid  in  1  sample offered
s_ready  out  1  sample accepted when s_valid & s_ready at posedge
s_T  in  8  sample temperature, signed Q7.0
cfg_valid  in  1  new parameter set offered
cfg_ready  out  1  config accepted when cfg_valid & cfg_ready at posedge
cfg_alpha  in  8  alpha, unsigned /256
cfg_k  in  8  k_dt shift
cfg_dmax  in  8  d_max clamp, Q7.0
restart  in  1  synchronous re-INIT request, level sampled at posedge
est_T_cur  out  8  to estimator T_cur
est_init  out  1  to estimator init, exactly 1-cycle pulse
est_alpha  out  8  to estimator alpha
est_k  out  8  to estimator k_dt
est_dmax  out  8  to estimator d_max
est_dT  in  8  from estimator dT_out
est_valid  in  1  from estimator dt_valid
dT_out  out  8  published dT, signed Q7.0, held between updates
dT_valid  out  1  1-cycle strobe when dT_out is updated
warm  out  1  high while in INIT or WARMUP
sat_alarm  out  1  sticky saturation flag, cleared on INIT
state  out  2  0 IDLE, 1 INIT, 2 WARMUP, 3 RUN

Behaviour:
- Reset values: s_ready=0, cfg_ready=0, est_T_cur=0, est_init=0, est_alpha=ALPHA_RST, est_k=K_RST, est_dmax=DMAX_RST, dT_out=0, dT_valid=0, warm=1, sat_alarm=0, state=IDLE. Internal warm-up count, saturation-run count and T_last all 0.
- IDLE: lasts one cycle after reset release, then goes to INIT.
- INIT: lasts one cycle.
  - est_init=1 for that cycle; est_T_cur holds T_last.
  - Warm-up and saturation-run counts clear; sat_alarm clears.
  - Next state is WARMUP. s_ready=0 and cfg_ready=0 in this state.
- Sample pipeline (WARMUP/RUN):
  - On accept (edge E0): est_T_cur <= s_T and T_last <= s_T.
  - The estimator updates at E1. The controller captures est_dT at E2, so latency from accept to dT_valid is 2 cycles.
  - s_ready=0 while a sample is in flight (from E0 until E2); at most one sample is in flight.
  - Between samples est_T_cur is held, not re-driven.
- WARMUP:
  - Each capture increments the warm-up count; dT_out is not updated and dT_valid stays 0.
  - When the count reaches WARMUP_SAMPLES, go to RUN. The first RUN-state capture is the first dT_valid.
- RUN: each capture sets dT_out <= est_dT and pulses dT_valid. If est_valid=0 at capture, no update and no strobe.
- Saturation:
  - A capture with |est_dT| == est_dmax increments the saturation-run count; any other capture clears it.
  - Count reaching SAT_RUN sets sat_alarm, which stays set until the next INIT.
- Config:
  - cfg_ready=1 only in WARMUP/RUN with no sample in flight.
  - On accept, est_alpha/est_k/est_dmax load the new set, with cfg_k saturated to 7 (values above 7 load as 7). Next state is INIT.
- Jump detection:
  - Jump magnitude is |s_T - T_last|, computed on 9-bit signed values.
  - If it exceeds JUMP_THR on an accepted sample, est_T_cur/T_last still load, no capture occurs, and the next state is INIT.
  - Jump detection is skipped for the first sample after INIT.
- Priority at the same edge: restart > cfg accept > sample accept.
  - restart high in WARMUP/RUN goes to INIT and discards any in-flight sample (no strobe).
  - cfg and sample are never both accepted: s_ready is forced 0 whenever cfg_valid=1 and cfg_ready=1.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately; no dT_valid is emitted for an in-flight sample.
- Arithmetic: the jump comparison uses 9-bit signed values; saturation compares 8-bit absolute values; |-128| is treated as 128.

Test Plan:
- Reset release, defaults: est_init pulses once at cycle 2 with est_alpha=32, est_k=3, est_dmax=64; state goes IDLE->INIT->WARMUP.
- Warm-up gating: 8 samples of T=10 -> no dT_valid; sample 9 (T=20) -> dT_valid exactly 2 cycles after accept with dT_out=est_dT.
- Config update: cfg alpha=128, k=9, dmax=10 in RUN -> est_k=7, one est_init pulse, warm=1, next 8 samples produce no dT_valid.
- Jump: RUN with T_last=0, sample T=40 (> 32) -> re-INIT, no strobe. A second INIT sample T=40 is accepted without a jump check.
- Saturation: est_dmax=10, feed 4 consecutive samples where est_dT=+10/-10 -> sat_alarm=1 after the 4th capture; restart -> sat_alarm=0.
- Priority and reset: restart, cfg_valid and s_valid high at the same edge -> INIT and s_ready=0. rst_n low during an in-flight sample -> dT_valid never asserts and all outputs are at reset values.

Source files
------------

// File: rtl/dt_est_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dt_est_ctrl
// Brief   : Sequencing/config controller for the EMA dT estimator datapath.
// Revision: 1.0
// ============================================================================
module dt_est_ctrl #(
    parameter int unsigned WARMUP_SAMPLES = 8,
    parameter int unsigned JUMP_THR       = 32,
    parameter int unsigned SAT_RUN        = 4,
    parameter int unsigned ALPHA_RST      = 32,
    parameter int unsigned K_RST          = 3,
    parameter int unsigned DMAX_RST       = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_T,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_alpha,
    input  logic [7:0] cfg_k,
    input  logic [7:0] cfg_dmax,
    input  logic       restart,
    output logic [7:0] est_T_cur,
    output logic       est_init,
    output logic [7:0] est_alpha,
    output logic [7:0] est_k,
    output logic [7:0] est_dmax,
    input  logic [7:0] est_dT,
    input  logic       est_valid,
    output logic [7:0] dT_out,
    output logic       dT_valid,
    output logic       warm,
    output logic       sat_alarm,
    output logic [1:0] state
);

    localparam logic [7:0] c_WARM  = 8'(WARMUP_SAMPLES);
    localparam logic [8:0] c_JTHR  = 9'(JUMP_THR);
    localparam logic [3:0] c_SAT   = 4'(SAT_RUN);
    localparam logic [7:0] c_ALPHA = 8'(ALPHA_RST);
    localparam logic [7:0] c_K     = 8'(K_RST);
    localparam logic [7:0] c_DMAX  = 8'(DMAX_RST);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INIT   = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_s_rdy;
    logic [1:0] r_ph;        // 0 idle, 1 estimator updating, 2 capture due
    logic       r_first;
    logic [7:0] r_t_last;
    logic [7:0] r_warm_cnt;
    logic [3:0] r_sat_cnt;

    logic       w_active;
    logic       w_cfg_acc;
    logic       w_s_acc;
    logic [8:0] w_diff;
    logic [8:0] w_jmag;
    logic       w_jump;
    logic [8:0] w_dabs;
    logic       w_sat_hit;
    logic [7:0] w_k_sat;
    logic [7:0] w_warm_nxt;
    logic [3:0] w_sat_nxt;
    logic       w_go_init;

    assign state     = r_state;
    assign w_active  = (r_state == ST_WARMUP) || (r_state == ST_RUN);
    assign w_cfg_acc = cfg_valid & cfg_ready;
    // A pending config always wins over a sample offered in the same cycle.
    assign s_ready   = r_s_rdy & ~w_cfg_acc;
    assign w_s_acc   = s_valid & s_ready;

    assign w_diff    = {s_T[7], s_T} - {r_t_last[7], r_t_last};
    assign w_jmag    = w_diff[8] ? (~w_diff + 9'd1) : w_diff;
    assign w_jump    = ~r_first && (w_jmag > c_JTHR);

    // 9-bit magnitude so that -128 compares as 128.
    assign w_dabs    = est_dT[7] ? ({1'b0, ~est_dT} + 9'd1) : {1'b0, est_dT};
    assign w_sat_hit = (w_dabs == {1'b0, est_dmax});
    assign w_k_sat   = (cfg_k > 8'd7) ? 8'd7 : cfg_k;
    assign w_warm_nxt = r_warm_cnt + 8'd1;
    assign w_sat_nxt  = (r_sat_cnt == c_SAT) ? r_sat_cnt : r_sat_cnt + 4'd1;

    assign w_go_init = (r_state == ST_IDLE) ||
                       (w_active && (restart || w_cfg_acc || (w_s_acc && w_jump)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_s_rdy    <= 1'b0;
            r_ph       <= 2'd0;
            r_first    <= 1'b1;
            r_t_last   <= 8'd0;
            r_warm_cnt <= 8'd0;
            r_sat_cnt  <= 4'd0;
            cfg_ready  <= 1'b0;
            est_T_cur  <= 8'd0;
            est_init   <= 1'b0;
            est_alpha  <= c_ALPHA;
            est_k      <= c_K;
            est_dmax   <= c_DMAX;
            dT_out     <= 8'd0;
            dT_valid   <= 1'b0;
            warm       <= 1'b1;
            sat_alarm  <= 1'b0;
        end else begin
            est_init <= 1'b0;
            dT_valid <= 1'b0;

            case (r_state)
                ST_INIT: begin
                    r_state   <= ST_WARMUP;
                    r_s_rdy   <= 1'b1;
                    cfg_ready <= 1'b1;
                end
                ST_WARMUP, ST_RUN: begin
                    if (restart) begin
                        r_ph <= 2'd0;
                    end else if (w_cfg_acc) begin
                        est_alpha <= cfg_alpha;
                        est_k     <= w_k_sat;
                        est_dmax  <= cfg_dmax;
                    end else if (w_s_acc) begin
                        est_T_cur <= s_T;
                        r_t_last  <= s_T;
                        r_first   <= 1'b0;
                        r_s_rdy   <= 1'b0;
                        cfg_ready <= 1'b0;
                        r_ph      <= w_jump ? 2'd0 : 2'd1;
                    end else if (r_ph == 2'd1) begin
                        r_ph <= 2'd2;
                    end else if (r_ph == 2'd2) begin
                        r_ph      <= 2'd0;
                        r_s_rdy   <= 1'b1;
                        cfg_ready <= 1'b1;
                        if (w_sat_hit) begin
                            r_sat_cnt <= w_sat_nxt;
                            if (w_sat_nxt == c_SAT) begin
                                sat_alarm <= 1'b1;
                            end
                        end else begin
                            r_sat_cnt <= 4'd0;
                        end
                        if (r_state == ST_WARMUP) begin
                            r_warm_cnt <= w_warm_nxt;
                            if (w_warm_nxt == c_WARM) begin
                                r_state <= ST_RUN;
                                warm    <= 1'b0;
                            end
                        end else if (est_valid) begin
                            dT_out   <= est_dT;
                            dT_valid <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Shared INIT entry; overrides whatever the branches above chose.
            if (w_go_init) begin
                r_state    <= ST_INIT;
                est_init   <= 1'b1;
                r_s_rdy    <= 1'b0;
                cfg_ready  <= 1'b0;
                r_ph       <= 2'd0;
                r_first    <= 1'b1;
                r_warm_cnt <= 8'd0;
                r_sat_cnt  <= 4'd0;
                sat_alarm  <= 1'b0;
                warm       <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
